// File: rtl/csi2tx_four_lane_pkt_packer.sv
// rtl/csi2tx_four_lane_pkt_packer.sv - CSI-2 packet header/payload/CRC byte packer into 64-bit FIFO words
// Define CSI2TX_PKT_CRC_EN to build the payload CRC-16; otherwise both CRC bytes are sent as 8'h00.
module csi2tx_four_lane_pkt_packer #(
  parameter logic [5:0]  LONG_DT_MIN = 6'h10,
  parameter logic [15:0] CRC_SEED    = 16'hFFFF
) (
  input  logic        txbyteclkhs,
  input  logic        txbyteclkhs_rst,
  input  logic        pkt_start,
  output logic        pkt_ready,
  input  logic [7:0]  pkt_di,
  input  logic [15:0] pkt_wc,
  input  logic [7:0]  pkt_ecc,
  input  logic [31:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [63:0] fifo_wr_data,
  output logic        short_packet,
  output logic [16:0] validated_word_cnt,
  output logic        eop_wr,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PLD, S_CRC, S_FLUSH, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [95:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] hdr_q, hdr_d;
  logic        short_q, short_d;
  logic [16:0] vwc_q, vwc_d;

  logic        pld_fire;
  logic [3:0]  base;
  logic [2:0]  nb;
  logic [31:0] app_data;
  logic [31:0] app_mask;
  logic [95:0] shifted;
  logic [16:0] vwc_long;

`ifdef CSI2TX_PKT_CRC_EN
  logic [15:0] crc_q, crc_d;

  // Reflected CRC-16 (poly 0x1021 -> 0x8408), bytes LSB-first, first n bytes of d.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] d,
                                          input logic [2:0] n);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 32; i++) begin
      if (i < 8 * int'(n)) begin
        fb = r[0] ^ d[i];
        r  = {1'b0, r[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
      end
    end
    return r;
  endfunction
`else
  logic unused_crc_seed;
  assign unused_crc_seed = ^CRC_SEED;
`endif

  assign vwc_long = ({1'b0, pkt_wc} + 17'd9) >> 2;

  always_comb begin
    case (nb)
      3'd1:    app_mask = 32'h0000_00FF;
      3'd2:    app_mask = 32'h0000_FFFF;
      3'd3:    app_mask = 32'h00FF_FFFF;
      3'd4:    app_mask = 32'hFFFF_FFFF;
      default: app_mask = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    hdr_d    = hdr_q;
    short_d  = short_q;
    vwc_d    = vwc_q;
`ifdef CSI2TX_PKT_CRC_EN
    crc_d    = crc_q;
`endif
    app_data = 32'd0;
    nb       = 3'd0;

    pkt_ready    = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    fifo_wr_en   = !fifo_full && ((cnt_q >= 4'd8) || ((state_q == S_FLUSH) && (cnt_q != 4'd0)));
    fifo_wr_data = fifo_wr_en ? acc_q[63:0] : 64'd0;
    eop_wr       = fifo_wr_en && (state_q == S_FLUSH) && (cnt_q <= 4'd8);
    pld_ready    = (state_q == S_PLD) && (cnt_q <= 4'd4) && !fifo_full;
    pld_fire     = pld_ready && pld_valid;

    // New bytes land just above whatever survives this cycle's write.
    shifted = fifo_wr_en ? {64'd0, acc_q[95:64]} : acc_q;
    if (fifo_wr_en) base = (cnt_q > 4'd8) ? (cnt_q - 4'd8) : 4'd0;
    else            base = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pkt_start) begin
          hdr_d   = {pkt_ecc, pkt_wc, pkt_di};
          rem_d   = pkt_wc;
          short_d = (pkt_di[5:0] < LONG_DT_MIN);
          vwc_d   = (pkt_di[5:0] < LONG_DT_MIN) ? 17'd1 : vwc_long;
`ifdef CSI2TX_PKT_CRC_EN
          crc_d   = CRC_SEED;
`endif
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        app_data = hdr_q;
        nb       = 3'd4;
        if (short_q)               state_d = S_FLUSH;
        else if (rem_q == 16'd0)   state_d = S_CRC;
        else                       state_d = S_PLD;
      end
      S_PLD: begin
        if (pld_fire) begin
          nb       = (rem_q >= 16'd4) ? 3'd4 : rem_q[2:0];
          app_data = pld_data;
          rem_d    = rem_q - {13'd0, nb};
`ifdef CSI2TX_PKT_CRC_EN
          crc_d    = crc_upd(crc_q, pld_data, nb);
`endif
          if (rem_q <= 16'd4) state_d = S_CRC;
        end
      end
      S_CRC: begin
`ifdef CSI2TX_PKT_CRC_EN
        app_data = {16'd0, crc_q};
`else
        app_data = 32'd0;
`endif
        nb       = 3'd2;
        state_d  = S_FLUSH;
      end
      S_FLUSH: begin
        if (eop_wr) state_d = S_DONE;
      end
      S_DONE: begin
        short_d = 1'b0;
        vwc_d   = 17'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    acc_d = shifted | ({64'd0, app_data & app_mask} << {base, 3'b000});
    cnt_d = base + {1'b0, nb};
  end

  always_ff @(posedge txbyteclkhs) begin
    if (txbyteclkhs_rst) begin
      state_q <= S_IDLE;
      acc_q   <= 96'd0;
      cnt_q   <= 4'd0;
      rem_q   <= 16'd0;
      hdr_q   <= 32'd0;
      short_q <= 1'b0;
      vwc_q   <= 17'd0;
`ifdef CSI2TX_PKT_CRC_EN
      crc_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      hdr_q   <= hdr_d;
      short_q <= short_d;
      vwc_q   <= vwc_d;
`ifdef CSI2TX_PKT_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign short_packet       = short_q;
  assign validated_word_cnt = vwc_q;

endmodule

// File: tb/tb_csi2tx_four_lane_pkt_packer.sv
// tb/tb_csi2tx_four_lane_pkt_packer.sv - randomized bench with a byte-stream model of the packet packer
`timescale 1ns/1ps
module tb_csi2tx_four_lane_pkt_packer;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clk;
  logic        rst;
  logic        pkt_start;
  logic        pkt_ready;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic [7:0]  pkt_ecc;
  logic [31:0] pld_data;
  logic        pld_valid;
  logic        pld_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [63:0] fifo_wr_data;
  logic        short_packet;
  logic [16:0] validated_word_cnt;
  logic        eop_wr;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  bit          exp_eop_q[$];
  bit          exp_short = 1'b0;
  int          exp_vwc = 0;
  bit          rand_full = 1'b0;
  int          stall_cnt = 0;
  int          wr_count = 0;
  bit          seen_wr = 1'b0;
  logic [63:0] first_wr = '0;
  logic [63:0] last_wr = '0;
  int          first_wr_cyc = 0;
  int          accept_cyc = 0;
  bit          obs_short = 1'b0;
  int          obs_vwc = 0;
  word_q_t     fixed_words;

  csi2tx_four_lane_pkt_packer dut (
    .txbyteclkhs       (clk),
    .txbyteclkhs_rst   (rst),
    .pkt_start         (pkt_start),
    .pkt_ready         (pkt_ready),
    .pkt_di            (pkt_di),
    .pkt_wc            (pkt_wc),
    .pkt_ecc           (pkt_ecc),
    .pld_data          (pld_data),
    .pld_valid         (pld_valid),
    .pld_ready         (pld_ready),
    .fifo_full         (fifo_full),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_wr_data      (fifo_wr_data),
    .short_packet      (short_packet),
    .validated_word_cnt(validated_word_cnt),
    .eop_wr            (eop_wr),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] crc16(input byte_q_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 16'h8408;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  // FIFO backpressure: directed stall count or random
  initial begin
    fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      fifo_full = (stall_cnt > 0) || (rand_full && ($urandom_range(0, 3) == 0));
      if (stall_cnt > 0) stall_cnt--;
    end
  end

  // Compare process
  initial begin
    logic [63:0] e;
    bit          ee;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (fifo_wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_write: got %h expected no write", fifo_wr_data);
        end else begin
          e  = exp_q.pop_front();
          ee = exp_eop_q.pop_front();
          if (fifo_wr_data !== e || eop_wr !== ee) begin
            errors++;
            $display("FAIL fifo_write: got data %h eop %b expected data %h eop %b",
                     fifo_wr_data, eop_wr, e, ee);
          end
        end
        wr_count++;
        if (!seen_wr) begin
          seen_wr      = 1'b1;
          first_wr     = fifo_wr_data;
          first_wr_cyc = cyc;
        end
        last_wr = fifo_wr_data;
      end else begin
        chk("eop_without_write", 64'(eop_wr), 64'd0);
      end
      if (fifo_full) chk("stall_outputs", 64'({fifo_wr_en, pld_ready}), 64'd0);
      if (busy) begin
        obs_short = short_packet;
        obs_vwc   = int'(validated_word_cnt);
        chk("short_packet", 64'(short_packet), 64'(exp_short));
        chk("validated_word_cnt", 64'(validated_word_cnt), 64'(exp_vwc));
        chk("pkt_ready_busy", 64'(pkt_ready), 64'd0);
      end else begin
        chk("idle_outputs", 64'({short_packet, validated_word_cnt, pld_ready}), 64'd0);
        chk("pkt_ready_idle", 64'(pkt_ready), 64'd1);
      end
    end
  end

  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                          input int gap_pct, input int abort_at, input int stall_at,
                          input int spur_at);
    word_q_t     words;
    byte_q_t     s;
    byte_q_t     pl;
    logic [31:0] wv;
    logic [15:0] c;
    logic [63:0] v;
    bit          is_long;
    bit          rdy;
    int          nw;
    int          t;
    is_long = (di[5:0] >= 6'h10);
    nw = is_long ? (int'(wc) + 3) / 4 : 0;
    for (int i = 0; i < nw; i++)
      words.push_back((fixed_words.size() > i) ? fixed_words[i] : $urandom);
    fixed_words.delete();

    s.push_back(di);
    s.push_back(wc[7:0]);
    s.push_back(wc[15:8]);
    s.push_back(ecc);
    if (is_long) begin
      for (int i = 0; i < int'(wc); i++) begin
        wv = words[i / 4];
        pl.push_back(wv[8 * (i % 4) +: 8]);
      end
`ifdef CSI2TX_PKT_CRC_EN
      c = crc16(pl);
`else
      c = 16'h0000;
`endif
      foreach (pl[i]) s.push_back(pl[i]);
      s.push_back(c[7:0]);
      s.push_back(c[15:8]);
    end
    while (s.size() % 8 != 0) s.push_back(8'h00);

    pkt_di    = di;
    pkt_wc    = wc;
    pkt_ecc   = ecc;
    pkt_start = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (pkt_ready) break;
      t++;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL header_accept_timeout: got pkt_ready 0 expected 1 within 200 cycles");
        pkt_start = 1'b0;
        return;
      end
    end
    accept_cyc = cyc;
    for (int w = 0; w < s.size() / 8; w++) begin
      v = '0;
      for (int k = 0; k < 8; k++) v[8 * k +: 8] = s[8 * w + k];
      exp_q.push_back(v);
      exp_eop_q.push_back(w == s.size() / 8 - 1);
    end
    @(posedge clk);
    #1;
    pkt_start = 1'b0;
    exp_short = !is_long;
    exp_vwc   = is_long ? (6 + int'(wc) + 3) / 4 : 1;

    for (int w = 0; w < nw; w++) begin
      if (w == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_eop_q.delete();
        return;
      end
      if (w == stall_at) stall_cnt = 5;
      if (w == spur_at) begin
        pkt_start = 1'b1;
        pkt_di    = 8'($urandom);
        pkt_wc    = 16'($urandom);
      end
      while ($urandom_range(0, 99) < gap_pct) begin
        @(posedge clk);
        #1;
      end
      pld_data  = words[w];
      pld_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        rdy = pld_ready;
        @(posedge clk);
        #1;
        if (rdy) break;
        t++;
        if (t > 500) begin
          checks++;
          errors++;
          $display("FAIL payload_timeout: got pld_ready 0 expected 1 within 500 cycles");
          break;
        end
      end
      pld_valid = 1'b0;
      pkt_start = 1'b0;
    end

    t = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      t++;
      if (t > 1000) begin
        checks++;
        errors++;
        $display("FAIL packet_end_timeout: got busy 1 expected 0 within 1000 cycles");
        break;
      end
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before 600us");
    $fatal(1);
  end

  initial begin
    byte_q_t     cv;
    byte_q_t     pl10;
    int          wr0;
    logic [15:0] exp_crc10;
    logic [7:0]  dir;
    logic [15:0] wcr;

    rst = 1'b1; pkt_start = 1'b0; pkt_di = '0; pkt_wc = '0; pkt_ecc = '0;
    pld_data = '0; pld_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pkt_ready", 64'(pkt_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("reset_wr_data", fifo_wr_data, 64'd0);
    chk("reset_pld_ready", 64'(pld_ready), 64'd0);
    chk("reset_eop", 64'(eop_wr), 64'd0);
    chk("reset_short", 64'(short_packet), 64'd0);
    chk("reset_vwc", 64'(validated_word_cnt), 64'd0);

    for (int i = 1; i <= 9; i++) cv.push_back(8'(8'h30 + i));
    chk("crc_model_check_value", 64'(crc16(cv)), 64'h6F91);

    // Short packet
    @(posedge clk); #1;
    wr0 = wr_count; seen_wr = 1'b0;
    send_pkt(8'h00, 16'h0001, 8'h07, 0, -1, -1, -1);
    chk("short_word", first_wr, 64'h0000_0000_0700_0100);
    chk("short_writes", 64'(wr_count - wr0), 64'd1);
    chk("short_latency", 64'(first_wr_cyc - accept_cyc), 64'd2);
    chk("short_flag", 64'(obs_short), 64'd1);
    chk("short_vwc", 64'(obs_vwc), 64'd1);

    // Long packet, empty payload
    @(posedge clk); #1;
    wr0 = wr_count; seen_wr = 1'b0;
    send_pkt(8'h2A, 16'h0000, 8'h1B, 0, -1, -1, -1);
`ifdef CSI2TX_PKT_CRC_EN
    chk("wc0_word", first_wr, 64'h0000_FFFF_1B00_002A);
`else
    chk("wc0_word", first_wr, 64'h0000_0000_1B00_002A);
`endif
    chk("wc0_writes", 64'(wr_count - wr0), 64'd1);
    chk("wc0_vwc", 64'(obs_vwc), 64'd2);
    chk("wc0_short", 64'(obs_short), 64'd0);

    // WC=10, last word truncated
    @(posedge clk); #1;
    wr0 = wr_count; seen_wr = 1'b0;
    fixed_words.push_back(32'h0403_0201);
    fixed_words.push_back(32'h0807_0605);
    fixed_words.push_back(32'hAABB_0A09);
    for (int i = 1; i <= 10; i++) pl10.push_back(8'(i));
`ifdef CSI2TX_PKT_CRC_EN
    exp_crc10 = crc16(pl10);
`else
    exp_crc10 = 16'h0000;
`endif
    send_pkt(8'h2A, 16'd10, 8'h33, 0, -1, -1, -1);
    chk("wc10_word0", first_wr, 64'h0403_0201_3300_0A2A);
    chk("wc10_word1_payload", 64'(last_wr[47:0]), 64'h0000_0A09_0807_0605);
    chk("wc10_crc", 64'(last_wr[63:48]), 64'(exp_crc10));
    chk("wc10_writes", 64'(wr_count - wr0), 64'd2);
    chk("wc10_vwc", 64'(obs_vwc), 64'd4);

    // Five-cycle FIFO stall mid-payload
    @(posedge clk); #1;
    wr0 = wr_count;
    send_pkt(8'h2B, 16'd32, 8'h44, 0, -1, 3, -1);
    chk("stall_writes", 64'(wr_count - wr0), 64'd5);

    // Reset after two payload words, then a short packet
    @(posedge clk); #1;
    send_pkt(8'h2C, 16'd40, 8'h55, 0, 2, -1, -1);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_pkt_ready", 64'(pkt_ready), 64'd1);
    @(posedge clk); #1;
    wr0 = wr_count;
    send_pkt(8'h01, 16'($urandom), 8'($urandom), 0, -1, -1, -1);
    chk("abort_then_short_writes", 64'(wr_count - wr0), 64'd1);

    // pkt_start pulsed while busy
    @(posedge clk); #1;
    wr0 = wr_count;
    send_pkt(8'h3F, 16'd24, 8'h66, 0, -1, -1, 1);
    repeat (3) @(negedge clk);
    chk("spurious_start_busy", 64'(busy), 64'd0);
    chk("spurious_start_writes", 64'(wr_count - wr0), 64'd4);

    // Random packets with random backpressure and payload gaps
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      rand_full = ($urandom_range(0, 1) == 1);
      dir = 8'($urandom);
      wcr = (dir[5:0] >= 6'h10) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      send_pkt(dir, wcr, 8'($urandom), $urandom_range(0, 40), -1, -1, -1);
    end
    rand_full = 1'b0;
    repeat (5) @(negedge clk);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
